serial_frame_tx: RTL
====================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame, legal 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit, legal 2..65535.
REQ-003 Parameter STOP_BITS, default 1, stop-bit count, legal 1 or 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data  input  DATA_W  payload, sampled only on accept.
REQ-007 data_valid  input  1  producer offers data.
REQ-008 data_ready  output  1  block can accept a frame this cycle.
REQ-009 op_bit  output  1  serial line, idle-high, LSB first.
REQ-010 idle  output  1  high while FSM is IDLE.
REQ-011 start  output  1  high while start bit is driven.
REQ-012 stop  output  1  high while any stop bit is driven.

Function
REQ-013 FSM states: IDLE, START, DATA, PARITY (macro only), STOP; exactly one state active.
REQ-014 Accept = data_valid & data_ready; data_ready = (state==IDLE) & ~rst.
REQ-015 On accept, data latched into shift register; next cycle state=START.
REQ-016 START: op_bit=0 for CLKS_PER_BIT cycles, then DATA.
REQ-017 DATA: DATA_W bits, LSB first, each CLKS_PER_BIT cycles; after bit DATA_W-1 go PARITY if enabled else STOP.
REQ-018 STOP: op_bit=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
REQ-019 Baud counter counts 0..CLKS_PER_BIT-1, clears on every state change; width $clog2(CLKS_PER_BIT*2).
REQ-020 Bit index counter 0..DATA_W-1, clears on entering DATA.
REQ-021 op_bit, idle, start, stop are registered; no glitches mid-bit.
REQ-022 data/data_valid changes after accept have no effect on frame in flight.
REQ-023 data_valid held high continuously: next frame accepted on the first IDLE cycle; inter-frame gap exactly 1 clk of op_bit=1.
REQ-024 Frame length from accept to return to IDLE = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, P=1 with parity else 0.

Reset
REQ-025 rst high at a clk edge: state=IDLE, op_bit=1, idle=1, start=0, stop=0, counters=0, shift register=0.
REQ-026 rst mid-frame aborts frame; line returns high next cycle; aborted data discarded, not retransmitted.
REQ-027 data_ready=0 during rst; =1 first cycle after rst deasserts.

Configuration
REQ-028 Macro SERIAL_FRAME_TX_PARITY_EN defined: PARITY state inserted after DATA, op_bit = even parity (XOR of latched data) for CLKS_PER_BIT cycles.
REQ-029 Macro undefined: PARITY state and parity logic absent; DATA goes directly to STOP.

Structure
REQ-030 Package serial_tx_pkg holds state enum typedef, state encoding constants, and legal-range constants for DATA_W/STOP_BITS.
REQ-031 One sub-module baud_tick_counter (param CLKS_PER_BIT; inputs clk, rst, clear; output tick on last cycle of a bit).
REQ-032 Illegal parameter values rejected at elaboration.

Verification
REQ-033 DATA_W=8, CLKS_PER_BIT=4, no parity, data=8'hAB accepted -> op_bit per 4-cycle bit: 0,1,1,0,1,0,1,0,1,1; idle returns after 40 cycles.
REQ-034 Same with SERIAL_FRAME_TX_PARITY_EN -> parity bit 1 after data (5 ones), frame 44 cycles.
REQ-035 STOP_BITS=2, CLKS_PER_BIT=4 -> stop high 8 cycles, stop output high 8 cycles.
REQ-036 data_valid held high, data=8'h55 then 8'h0F -> two frames, exactly 1 idle cycle between, data_ready high only in IDLE.
REQ-037 rst asserted during DATA bit 3 -> next cycle op_bit=1, idle=1, start=stop=0; next accepted frame correct.
REQ-038 data changed from 8'hAB to 8'h00 one cycle after accept -> transmitted bits still 8'hAB.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared types and constants for serial_frame_tx
// Contents: FSM state enum, its encoding constants, legal parameter ranges.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (adds the PARITY state).
package serial_tx_pkg;

    localparam int DATA_W_MIN       = 5;
    localparam int DATA_W_MAX       = 9;
    localparam int STOP_BITS_MIN    = 1;
    localparam int STOP_BITS_MAX    = 2;
    localparam int CLKS_PER_BIT_MIN = 2;
    localparam int CLKS_PER_BIT_MAX = 65535;

    localparam logic [2:0] ENC_IDLE   = 3'd0;
    localparam logic [2:0] ENC_START  = 3'd1;
    localparam logic [2:0] ENC_DATA   = 3'd2;
    localparam logic [2:0] ENC_PARITY = 3'd3;
    localparam logic [2:0] ENC_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ENC_IDLE,
        ST_START  = ENC_START,
        ST_DATA   = ENC_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        ST_PARITY = ENC_PARITY,
`endif
        ST_STOP   = ENC_STOP
    } state_e;

endpackage

// File: rtl/baud_tick_counter.sv
// rtl/baud_tick_counter.sv - per-bit cycle counter producing a tick on the last cycle of a bit
// Ports: clk, rst (sync active-high), clear (hold count at 0), tick (last cycle of a bit).
module baud_tick_counter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                CNT_W = $clog2(CLKS_PER_BIT * 2);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count wraps to 0 on tick, so every bit boundary (and therefore every
    // state change driven by tick) starts the next bit from zero.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST) & ~clear;

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - idle-high, LSB-first serial frame transmitter
// Ports: clk, rst (sync active-high), data/data_valid/data_ready (accept handshake),
//        op_bit (serial line), idle/start/stop (registered FSM status flags).
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN (even parity bit after data).
module serial_frame_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              op_bit,
    output logic              idle,
    output logic              start,
    output logic              stop
);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
        $error("serial_frame_tx: DATA_W out of range");
    end
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX) begin : g_bad_cpb
        $error("serial_frame_tx: CLKS_PER_BIT out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
        $error("serial_frame_tx: STOP_BITS out of range");
    end

    localparam int               IDX_W         = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    state_e            r_state;
    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_tick;
    logic w_accept;
    logic w_clear;

    assign data_ready = (r_state == ST_IDLE) & ~rst;
    assign w_accept   = data_valid & data_ready;
    // Counter is parked at zero while idle so the start bit gets a full period.
    assign w_clear    = (r_state == ST_IDLE);

    baud_tick_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Outputs are computed one cycle ahead of the state they describe so that
    // op_bit and the flags change exactly on bit boundaries with no decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            op_bit    <= 1'b1;
            idle      <= 1'b1;
            start     <= 1'b0;
            stop      <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_START;
                        r_shift <= data;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        r_parity <= ^data;
`endif
                        op_bit  <= 1'b0;
                        idle    <= 1'b0;
                        start   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_state   <= ST_DATA;
                        r_bit_idx <= '0;
                        op_bit    <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                        start     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_idx == LAST_DATA_IDX) begin
                            r_bit_idx <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                            r_state   <= ST_PARITY;
                            op_bit    <= r_parity;
`else
                            r_state   <= ST_STOP;
                            op_bit    <= 1'b1;
                            stop      <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            op_bit    <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                        end
                    end
                end
`ifdef SERIAL_FRAME_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_state   <= ST_STOP;
                        r_bit_idx <= '0;
                        op_bit    <= 1'b1;
                        stop      <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // r_bit_idx is reused to count stop bits.
                    if (w_tick) begin
                        if (r_bit_idx == LAST_STOP_IDX) begin
                            r_state   <= ST_IDLE;
                            r_bit_idx <= '0;
                            op_bit    <= 1'b1;
                            idle      <= 1'b1;
                            stop      <= 1'b0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    op_bit  <= 1'b1;
                    idle    <= 1'b1;
                    start   <= 1'b0;
                    stop    <= 1'b0;
                end
            endcase
        end
    end

endmodule
